// File: rtl/read_iq_n.sv
// Unpacks SPW complex I/Q lanes per FWFT input word and writes them, scaled by FRAC_BITS, to paired I/Q FIFOs.
// Optional macro READ_IQ_N_CONJ_EN negates Q (complex conjugate) with saturation of the most negative value.
module read_iq_n #(
   parameter int SAMPLE_W  = 16,
   parameter int SPW       = 2,
   parameter int OUT_W     = 32,
   parameter int FRAC_BITS = 10,
   localparam int IN_W     = 2*SAMPLE_W*SPW
) (
   input  logic                    clock,
   input  logic                    reset,
   output logic                    inA_rd_en,
   input  logic                    inA_empty,
   input  logic [IN_W-1:0]         inA_dout,
   output logic                    out_wr_en,
   input  logic                    out_full,
   output logic signed [OUT_W-1:0] out_din,
   output logic                    out_wr_en_2,
   input  logic                    out_full_2,
   output logic signed [OUT_W-1:0] out_din_2,
   output logic [31:0]             sample_cnt,
   output logic                    busy
);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t                state_q, state_d;
   logic [2:0]            lane_q, lane_d;
   logic [IN_W-1:0]       hold_q, hold_d;
   logic [31:0]           sample_cnt_q, sample_cnt_d;

   logic [2*SAMPLE_W-1:0] lane_word;
   logic [SAMPLE_W-1:0]   i_raw, q_raw, q_adj;
   logic                  can_write, last_lane, do_write, do_pop;

   function automatic logic [OUT_W-1:0] quant(input logic [SAMPLE_W-1:0] s);
      logic [OUT_W-1:0] e;
      e = {{(OUT_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
      return e << FRAC_BITS;
   endfunction

   always_comb begin
      lane_word = '0;
      for (int k = 0; k < SPW; k++) begin
         if (lane_q == 3'(k)) lane_word = hold_q[2*SAMPLE_W*k +: 2*SAMPLE_W];
      end
   end

   assign i_raw = lane_word[2*SAMPLE_W-1:SAMPLE_W];
   assign q_raw = lane_word[SAMPLE_W-1:0];

`ifdef READ_IQ_N_CONJ_EN
   // The most negative value has no positive twin, so it clamps to the maximum.
   assign q_adj = (q_raw == {1'b1, {(SAMPLE_W-1){1'b0}}}) ? {1'b0, {(SAMPLE_W-1){1'b1}}} : -q_raw;
`else
   assign q_adj = q_raw;
`endif

   // Strobes stay combinational so full/empty are honoured in the very cycle they are seen.
   assign can_write = (state_q == EMIT) && !out_full && !out_full_2;
   assign last_lane = (lane_q == 3'(SPW-1));
   assign do_write  = !reset && can_write;
   assign do_pop    = !reset && !inA_empty && ((state_q == IDLE) || (can_write && last_lane));

   assign inA_rd_en   = do_pop;
   assign out_wr_en   = do_write;
   assign out_wr_en_2 = do_write;
   assign out_din     = do_write ? quant(i_raw) : '0;
   assign out_din_2   = do_write ? quant(q_adj) : '0;
   assign sample_cnt  = sample_cnt_q;
   assign busy        = (state_q == EMIT);

   always_comb begin
      state_d      = state_q;
      lane_d       = lane_q;
      hold_d       = hold_q;
      sample_cnt_d = sample_cnt_q;
      if (do_write) begin
         sample_cnt_d = sample_cnt_q + 32'd1;
         if (!last_lane) lane_d = lane_q + 3'd1;
         else            state_d = IDLE;
      end
      if (do_pop) begin
         hold_d  = inA_dout;
         lane_d  = '0;
         state_d = EMIT;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         lane_q       <= '0;
         hold_q       <= '0;
         sample_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         lane_q       <= lane_d;
         hold_q       <= hold_d;
         sample_cnt_q <= sample_cnt_d;
      end
   end

endmodule

// File: tb/tb_read_iq_n.sv
// Directed self-checking bench for read_iq_n (SAMPLE_W=16, SPW=2, OUT_W=32, FRAC_BITS=10).
// Expected Q values follow READ_IQ_N_CONJ_EN when the bench is built with it.
module tb_read_iq_n;

   logic               clock = 1'b0;
   logic               reset;
   logic               inA_rd_en;
   logic               inA_empty;
   logic [63:0]        inA_dout;
   logic               out_wr_en, out_full, out_wr_en_2, out_full_2;
   logic signed [31:0] out_din, out_din_2;
   logic [31:0]        sample_cnt;
   logic               busy;

   int cmp_cnt  = 0;
   int fail_cnt = 0;

`ifdef READ_IQ_N_CONJ_EN
   localparam logic [31:0] SW_Q0 = 32'h0000_0400, SW_Q1 = 32'h01FF_FC00;
   localparam logic [31:0] BP_Q0 = 32'hFFFF_F800, BP_Q1 = 32'hFFFF_F000;
   localparam logic [31:0] RM_Q0 = 32'hFFFF_D000, RM_Q1 = 32'hFFFF_D800;
`else
   localparam logic [31:0] SW_Q0 = 32'hFFFF_FC00, SW_Q1 = 32'hFE00_0000;
   localparam logic [31:0] BP_Q0 = 32'h0000_0800, BP_Q1 = 32'h0000_1000;
   localparam logic [31:0] RM_Q0 = 32'h0000_3000, RM_Q1 = 32'h0000_2800;
`endif

   read_iq_n #(.SAMPLE_W(16), .SPW(2), .OUT_W(32), .FRAC_BITS(10)) dut (
      .clock(clock), .reset(reset),
      .inA_rd_en(inA_rd_en), .inA_empty(inA_empty), .inA_dout(inA_dout),
      .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din),
      .out_wr_en_2(out_wr_en_2), .out_full_2(out_full_2), .out_din_2(out_din_2),
      .sample_cnt(sample_cnt), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic test_reset();
      reset = 1'b1; inA_empty = 1'b0; inA_dout = 64'h1234_5678_9ABC_DEF0;
      out_full = 1'b0; out_full_2 = 1'b0;
      repeat (2) @(negedge clock);
      #1;
      cmp_cnt++; if (inA_rd_en !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_rd_en: got %b expected 0", inA_rd_en); end
      cmp_cnt++; if ({out_wr_en, out_wr_en_2} !== 2'b00) begin fail_cnt++; $display("[TB] FAIL reset_wr_en: got %b expected 00", {out_wr_en, out_wr_en_2}); end
      cmp_cnt++; if ({out_din, out_din_2} !== 64'd0) begin fail_cnt++; $display("[TB] FAIL reset_din: got %h expected 0", {out_din, out_din_2}); end
      cmp_cnt++; if (sample_cnt !== 32'd0) begin fail_cnt++; $display("[TB] FAIL reset_cnt: got %h expected 0", sample_cnt); end
      cmp_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
      @(negedge clock);
      reset = 1'b0; inA_empty = 1'b1; inA_dout = '0;
      #1;
      cmp_cnt++; if (inA_rd_en !== 1'b0) begin fail_cnt++; $display("[TB] FAIL idle_empty_rd_en: got %b expected 0", inA_rd_en); end
   endtask

   task automatic test_single_word();
      @(negedge clock);
      inA_empty = 1'b0; inA_dout = 64'h7FFF_8000_0001_FFFF;
      #1;
      cmp_cnt++; if (inA_rd_en !== 1'b1) begin fail_cnt++; $display("[TB] FAIL single_pop: got %b expected 1", inA_rd_en); end
      cmp_cnt++; if (out_wr_en !== 1'b0) begin fail_cnt++; $display("[TB] FAIL single_no_early_wr: got %b expected 0", out_wr_en); end
      @(negedge clock);
      inA_empty = 1'b1; inA_dout = '0;
      #1;
      cmp_cnt++; if ({out_wr_en, out_wr_en_2, inA_rd_en} !== 3'b110) begin fail_cnt++; $display("[TB] FAIL single_l0_strobes: got %b expected 110", {out_wr_en, out_wr_en_2, inA_rd_en}); end
      cmp_cnt++; if (out_din !== 32'h0000_0400) begin fail_cnt++; $display("[TB] FAIL single_l0_i: got %h expected 00000400", out_din); end
      cmp_cnt++; if (out_din_2 !== SW_Q0) begin fail_cnt++; $display("[TB] FAIL single_l0_q: got %h expected %h", out_din_2, SW_Q0); end
      @(negedge clock);
      #1;
      cmp_cnt++; if ({out_wr_en, out_wr_en_2, inA_rd_en} !== 3'b110) begin fail_cnt++; $display("[TB] FAIL single_l1_strobes: got %b expected 110", {out_wr_en, out_wr_en_2, inA_rd_en}); end
      cmp_cnt++; if (out_din !== 32'h01FF_FC00) begin fail_cnt++; $display("[TB] FAIL single_l1_i: got %h expected 01fffc00", out_din); end
      cmp_cnt++; if (out_din_2 !== SW_Q1) begin fail_cnt++; $display("[TB] FAIL single_l1_q: got %h expected %h", out_din_2, SW_Q1); end
      @(negedge clock);
      #1;
      cmp_cnt++; if ({out_wr_en, busy} !== 2'b00) begin fail_cnt++; $display("[TB] FAIL single_idle: got wr/busy %b expected 00", {out_wr_en, busy}); end
      cmp_cnt++; if ({out_din, out_din_2} !== 64'd0) begin fail_cnt++; $display("[TB] FAIL single_idle_din: got %h expected 0", {out_din, out_din_2}); end
      cmp_cnt++; if (sample_cnt !== 32'd2) begin fail_cnt++; $display("[TB] FAIL single_cnt: got %0d expected 2", sample_cnt); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] words [4];
      logic [31:0] exp_i, exp_q;
      logic        exp_rd, exp_wr;
      int          ptr = 0;
      for (int s = 0; s < 8; s++) words[s/2][32*(s%2) +: 32] = {16'(16'h0100 + s), 16'(s + 1)};
      for (int c = 0; c < 9; c++) begin
         @(negedge clock);
         inA_empty = (ptr >= 4);
         inA_dout  = (ptr < 4) ? words[ptr] : 64'd0;
         #1;
         exp_rd = (c == 0) || (c == 2) || (c == 4) || (c == 6);
         exp_wr = (c >= 1);
         exp_i  = exp_wr ? 32'((256 + c - 1) * 1024) : 32'd0;
`ifdef READ_IQ_N_CONJ_EN
         exp_q  = exp_wr ? 32'(-c * 1024) : 32'd0;
`else
         exp_q  = exp_wr ? 32'(c * 1024) : 32'd0;
`endif
         cmp_cnt++; if (inA_rd_en !== exp_rd) begin fail_cnt++; $display("[TB] FAIL b2b_rd_en[%0d]: got %b expected %b", c, inA_rd_en, exp_rd); end
         cmp_cnt++; if ({out_wr_en, out_wr_en_2} !== {exp_wr, exp_wr}) begin fail_cnt++; $display("[TB] FAIL b2b_wr_en[%0d]: got %b expected %b", c, {out_wr_en, out_wr_en_2}, {exp_wr, exp_wr}); end
         cmp_cnt++; if (out_din !== exp_i) begin fail_cnt++; $display("[TB] FAIL b2b_i[%0d]: got %h expected %h", c, out_din, exp_i); end
         cmp_cnt++; if (out_din_2 !== exp_q) begin fail_cnt++; $display("[TB] FAIL b2b_q[%0d]: got %h expected %h", c, out_din_2, exp_q); end
         if (inA_rd_en) ptr++;
      end
      @(negedge clock);
      inA_empty = 1'b1; inA_dout = '0;
      #1;
      cmp_cnt++; if (busy !== 1'b0) begin fail_cnt++; $display("[TB] FAIL b2b_idle: got %b expected 0", busy); end
      cmp_cnt++; if (sample_cnt !== 32'd10) begin fail_cnt++; $display("[TB] FAIL b2b_cnt: got %0d expected 10", sample_cnt); end
   endtask

   task automatic test_backpressure();
      @(negedge clock);
      inA_empty = 1'b0; inA_dout = 64'h0003_0004_0001_0002;
      #1;
      cmp_cnt++; if (inA_rd_en !== 1'b1) begin fail_cnt++; $display("[TB] FAIL bp_pop: got %b expected 1", inA_rd_en); end
      @(negedge clock);
      inA_empty = 1'b1; inA_dout = '0;
      #1;
      cmp_cnt++; if ({out_din, out_din_2} !== {32'h0000_0400, BP_Q0}) begin fail_cnt++; $display("[TB] FAIL bp_l0: got %h expected %h", {out_din, out_din_2}, {32'h0000_0400, BP_Q0}); end
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         out_full_2 = 1'b1;
         #1;
         cmp_cnt++; if ({out_wr_en, out_wr_en_2, busy} !== 3'b001) begin fail_cnt++; $display("[TB] FAIL bp_stall[%0d]: got wr/wr2/busy %b expected 001", c, {out_wr_en, out_wr_en_2, busy}); end
         cmp_cnt++; if ({out_din, out_din_2} !== 64'd0) begin fail_cnt++; $display("[TB] FAIL bp_stall_din[%0d]: got %h expected 0", c, {out_din, out_din_2}); end
         cmp_cnt++; if (sample_cnt !== 32'd11) begin fail_cnt++; $display("[TB] FAIL bp_stall_cnt[%0d]: got %0d expected 11", c, sample_cnt); end
      end
      @(negedge clock);
      out_full_2 = 1'b0;
      #1;
      cmp_cnt++; if ({out_wr_en, out_wr_en_2} !== 2'b11) begin fail_cnt++; $display("[TB] FAIL bp_resume_wr: got %b expected 11", {out_wr_en, out_wr_en_2}); end
      cmp_cnt++; if ({out_din, out_din_2} !== {32'h0000_0C00, BP_Q1}) begin fail_cnt++; $display("[TB] FAIL bp_l1: got %h expected %h", {out_din, out_din_2}, {32'h0000_0C00, BP_Q1}); end
      @(negedge clock);
      #1;
      cmp_cnt++; if (sample_cnt !== 32'd12) begin fail_cnt++; $display("[TB] FAIL bp_cnt: got %0d expected 12", sample_cnt); end
   endtask

   task automatic test_reset_mid_word();
      @(negedge clock);
      inA_empty = 1'b0; inA_dout = 64'h0005_0006_0007_0008;
      #1;
      cmp_cnt++; if (inA_rd_en !== 1'b1) begin fail_cnt++; $display("[TB] FAIL rm_pop: got %b expected 1", inA_rd_en); end
      @(negedge clock);
      inA_empty = 1'b1; inA_dout = '0;
      #1;
      cmp_cnt++; if (out_din !== 32'h0000_1C00) begin fail_cnt++; $display("[TB] FAIL rm_l0_i: got %h expected 00001c00", out_din); end
      @(negedge clock);
      reset = 1'b1; inA_empty = 1'b0; inA_dout = 64'h0009_000A_000B_000C;
      #1;
      cmp_cnt++; if ({inA_rd_en, out_wr_en, out_wr_en_2} !== 3'b000) begin fail_cnt++; $display("[TB] FAIL rm_in_reset_strobes: got %b expected 000", {inA_rd_en, out_wr_en, out_wr_en_2}); end
      cmp_cnt++; if ({out_din, out_din_2} !== 64'd0) begin fail_cnt++; $display("[TB] FAIL rm_in_reset_din: got %h expected 0", {out_din, out_din_2}); end
      @(negedge clock);
      reset = 1'b0;
      #1;
      cmp_cnt++; if ({busy, out_wr_en, inA_rd_en} !== 3'b001) begin fail_cnt++; $display("[TB] FAIL rm_after_reset: got busy/wr/rd %b expected 001", {busy, out_wr_en, inA_rd_en}); end
      cmp_cnt++; if (sample_cnt !== 32'd0) begin fail_cnt++; $display("[TB] FAIL rm_cnt_cleared: got %0d expected 0", sample_cnt); end
      @(negedge clock);
      inA_empty = 1'b1; inA_dout = '0;
      #1;
      cmp_cnt++; if ({out_din, out_din_2} !== {32'h0000_2C00, RM_Q0}) begin fail_cnt++; $display("[TB] FAIL rm_restart_l0: got %h expected %h", {out_din, out_din_2}, {32'h0000_2C00, RM_Q0}); end
      @(negedge clock);
      #1;
      cmp_cnt++; if ({out_din, out_din_2} !== {32'h0000_2400, RM_Q1}) begin fail_cnt++; $display("[TB] FAIL rm_restart_l1: got %h expected %h", {out_din, out_din_2}, {32'h0000_2400, RM_Q1}); end
      @(negedge clock);
      #1;
      cmp_cnt++; if (sample_cnt !== 32'd2) begin fail_cnt++; $display("[TB] FAIL rm_cnt: got %0d expected 2", sample_cnt); end
   endtask

   task automatic test_cnt_wrap();
      @(negedge clock);
      inA_empty = 1'b1;
      force dut.sample_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.sample_cnt_q;
      @(negedge clock);
      #1;
      cmp_cnt++; if (sample_cnt !== 32'hFFFF_FFFF) begin fail_cnt++; $display("[TB] FAIL wrap_preload: got %h expected ffffffff", sample_cnt); end
      @(negedge clock);
      inA_empty = 1'b0; inA_dout = 64'h0001_0001_0001_0001;
      @(negedge clock);
      inA_empty = 1'b1; inA_dout = '0;
      @(negedge clock);
      #1;
      cmp_cnt++; if (sample_cnt !== 32'd0) begin fail_cnt++; $display("[TB] FAIL wrap_zero: got %h expected 00000000", sample_cnt); end
      @(negedge clock);
      #1;
      cmp_cnt++; if (sample_cnt !== 32'd1) begin fail_cnt++; $display("[TB] FAIL wrap_next: got %h expected 00000001", sample_cnt); end
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_word();
      test_cnt_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", cmp_cnt, fail_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/read_iq_n.md
READ_IQ_N -- requirements
Module: read_iq_n

Interface
- REQ-001: Parameter SAMPLE_W, default 16, width of each packed I or Q sample.
- REQ-002: Parameter SPW, default 2, number of complex samples (lanes) per input word, range 1..8.
- REQ-003: Parameter OUT_W, default 32, output sample width; OUT_W >= SAMPLE_W+FRAC_BITS+1.
- REQ-004: Parameter FRAC_BITS, default 10, left-shift applied during quantisation.
- REQ-005: Derived IN_W = 2*SAMPLE_W*SPW.
- REQ-006: clock  in  1  single clock; all logic on its rising edge.
- REQ-007: reset  in  1  synchronous, active-high reset.
- REQ-008: inA_rd_en  out  1  pop strobe to the input FIFO.
- REQ-009: inA_empty  in  1  input FIFO empty.
- REQ-010: inA_dout  in  IN_W  input word; first-word-fall-through, valid whenever inA_empty=0.
- REQ-011: out_wr_en / out_full / out_din  out/in/out  1/1/OUT_W signed  I sample FIFO port.
- REQ-012: out_wr_en_2 / out_full_2 / out_din_2  out/in/out  1/1/OUT_W signed  Q sample FIFO port.
- REQ-013: sample_cnt  out  32  count of complex samples emitted, wraps modulo 2^32.
- REQ-014: busy  out  1  high when a word is held (state EMIT).

Function
- REQ-015: Lane k occupies inA_dout[2*SAMPLE_W*(k+1)-1 : 2*SAMPLE_W*k]; upper SAMPLE_W bits are I, lower are Q; lane 0 is emitted first.
- REQ-016: Quantisation: sign-extend sample to OUT_W, then shift left FRAC_BITS; result is exact (no overflow given REQ-003).
- REQ-017: States IDLE and EMIT; 3-bit-min lane counter lane.
- REQ-018: IDLE: if inA_empty=0, assert inA_rd_en for one cycle, capture word into hold register, lane<=0, go EMIT; else stay.
- REQ-019: EMIT: a lane is written only when out_full=0 AND out_full_2=0; then out_wr_en and out_wr_en_2 both assert the same cycle with lane's I and Q; I and Q FIFOs are never written independently.
- REQ-020: EMIT with either full asserted: no writes, lane, hold register and state unchanged.
- REQ-021: EMIT writing lane SPW-1: if inA_empty=0, also assert inA_rd_en, capture next word, lane<=0, remain EMIT (back-to-back, one complex sample per cycle sustained); else go IDLE.
- REQ-022: EMIT writing lane < SPW-1: lane<=lane+1, inA_rd_en=0.
- REQ-023: Latency: word popped in cycle N, lane 0 written earliest in cycle N+1.
- REQ-024: out_din and out_din_2 are 0 in any cycle their wr_en is 0.
- REQ-025: sample_cnt increments by 1 on each write cycle; 0xFFFFFFFF wraps to 0.
- REQ-026: inA_rd_en never asserts while inA_empty=1.

Reset
- REQ-027: reset has priority over all other inputs in the same cycle.
- REQ-028: On reset: state IDLE, lane 0, hold register 0, sample_cnt 0; all strobes and data outputs 0 in the cycle after reset is sampled.
- REQ-029: Reset mid-word discards remaining lanes; no partial write completes, FIFO is not popped during reset.

Configuration
- REQ-030: Macro READ_IQ_N_CONJ_EN defined: Q is negated before quantisation (complex conjugate); -2^(SAMPLE_W-1) saturates to 2^(SAMPLE_W-1)-1.
- REQ-031: Macro undefined: Q passes unmodified; no negation logic present.

Verification (SAMPLE_W=16, SPW=2, OUT_W=32, FRAC_BITS=10)
- REQ-032: One word 0x7FFF8000_0001FFFF, outputs never full -> cycle+1: I=0x00000400, Q=0xFFFFFC00; cycle+2: I=0x01FFFC00, Q=0xFE000000; sample_cnt=2, IDLE.
- REQ-033: Same word with READ_IQ_N_CONJ_EN -> lane0 Q=0x00000400; lane1 Q=0x01FFFC00 (saturated).
- REQ-034: Four words queued, outputs never full -> 8 consecutive write cycles, inA_rd_en on cycles 0,2,4,6, no bubbles.
- REQ-035: out_full_2=1 for 3 cycles during lane 1 -> no writes to either FIFO for 3 cycles, lane 1 then written with unchanged data.
- REQ-036: reset pulse while lane 1 pending -> no lane-1 write, all outputs 0, next word restarts at lane 0.
- REQ-037: sample_cnt forced via 2^32-1 samples (or preloaded in sim) -> next write wraps it to 0.
